// File: rtl/stopwatch_scan.sv
// MM:SS stopwatch counting synchronized 1 s ticks, with a registered
// 4-digit seven-segment scan stage feeding the segment decoder.
module stopwatch_scan #(
    parameter int unsigned MIN_LIMIT = 59,
    parameter bit          WRAP      = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sec_clk,
    input  logic [1:0]  ftsd_clk,
    input  logic        btn_start,
    input  logic        btn_clear,
    output logic [3:0]  ftsd_ctl,
    output logic [3:0]  ftsd_bcd,
    output logic [15:0] digits,
    output logic        running,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    localparam logic [3:0]  LIM_TENS = 4'(MIN_LIMIT / 10);
    localparam logic [3:0]  LIM_ONES = 4'(MIN_LIMIT % 10);
    localparam logic [15:0] LIMIT    = {LIM_TENS, LIM_ONES, 4'd5, 4'd9};

    state_t      state, state_n;
    logic [15:0] digits_n, digits_inc;
    logic        sync_a, sync_b, sync_prev, sec_tick;

    // Registered edge detect adds the third cycle of tick latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a    <= 1'b0;
            sync_b    <= 1'b0;
            sync_prev <= 1'b0;
            sec_tick  <= 1'b0;
        end else begin
            sync_a    <= sec_clk;
            sync_b    <= sync_a;
            sync_prev <= sync_b;
            sec_tick  <= sync_b & ~sync_prev;
        end
    end

    always_comb begin
        digits_inc = digits;
        if (digits[3:0] != 4'd9) begin
            digits_inc[3:0] = digits[3:0] + 4'd1;
        end else begin
            digits_inc[3:0] = '0;
            if (digits[7:4] != 4'd5) begin
                digits_inc[7:4] = digits[7:4] + 4'd1;
            end else begin
                digits_inc[7:4] = '0;
                if (digits[11:8] != 4'd9) begin
                    digits_inc[11:8] = digits[11:8] + 4'd1;
                end else begin
                    digits_inc[11:8]  = '0;
                    digits_inc[15:12] = digits[15:12] + 4'd1;
                end
            end
        end
    end

    // Tick is resolved before start so a tick+start in RUN counts first.
    always_comb begin
        state_n  = state;
        digits_n = digits;
        if (btn_clear) begin
            state_n  = IDLE;
            digits_n = '0;
        end else begin
            if (state == RUN && sec_tick) begin
                if (digits == LIMIT) begin
                    if (WRAP) digits_n = '0;
                    else      state_n  = DONE;
                end else begin
                    digits_n = digits_inc;
                end
            end
            if (btn_start) begin
                case (state)
                    IDLE, PAUSE: state_n = RUN;
                    RUN:         if (state_n == RUN) state_n = PAUSE;
                    default:     ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            digits   <= '0;
            running  <= 1'b0;
            done     <= 1'b0;
            ftsd_ctl <= '1;
            ftsd_bcd <= '0;
        end else begin
            state   <= state_n;
            digits  <= digits_n;
            running <= (state_n == RUN);
            done    <= (state_n == DONE);
            case (ftsd_clk)
                2'b00: begin ftsd_ctl <= 4'b1110; ftsd_bcd <= digits_n[3:0];   end
                2'b01: begin ftsd_ctl <= 4'b1101; ftsd_bcd <= digits_n[7:4];   end
                2'b10: begin ftsd_ctl <= 4'b1011; ftsd_bcd <= digits_n[11:8];  end
                default: begin ftsd_ctl <= 4'b0111; ftsd_bcd <= digits_n[15:12]; end
            endcase
        end
    end

endmodule

// File: tb/tb_stopwatch_scan.sv
// Bench for stopwatch_scan: a hold-at-limit and a wrapping instance share
// stimulus and are compared against a seconds-count reference model.
module tb_stopwatch_scan;

    localparam int LIM_SECS = 59 * 60 + 59;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    logic        clk = 1'b0;
    logic        rst, sec_clk, btn_start, btn_clear;
    logic [1:0]  ftsd_clk;
    logic [3:0]  ctl0, bcd0, ctl1, bcd1;
    logic [15:0] dig0, dig1;
    logic        run0, run1, done0, done1;

    int total = 0;
    int bad   = 0;
    int secs[2];
    int mst[2];

    stopwatch_scan #(.MIN_LIMIT(59), .WRAP(1'b0)) dut0 (
        .clk(clk), .rst(rst), .sec_clk(sec_clk), .ftsd_clk(ftsd_clk),
        .btn_start(btn_start), .btn_clear(btn_clear),
        .ftsd_ctl(ctl0), .ftsd_bcd(bcd0), .digits(dig0), .running(run0), .done(done0)
    );

    stopwatch_scan #(.MIN_LIMIT(59), .WRAP(1'b1)) dut1 (
        .clk(clk), .rst(rst), .sec_clk(sec_clk), .ftsd_clk(ftsd_clk),
        .btn_start(btn_start), .btn_clear(btn_clear),
        .ftsd_ctl(ctl1), .ftsd_bcd(bcd1), .digits(dig1), .running(run1), .done(done1)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [15:0] to_bcd(int s);
        int m = s / 60;
        int r = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(r / 10), 4'(r % 10)};
    endfunction

    task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_step(bit tk, bit st, bit cl);
        for (int i = 0; i < 2; i++) begin
            int ns;
            if (cl) begin
                secs[i] = 0;
                mst[i]  = M_IDLE;
            end else begin
                ns = mst[i];
                if (tk && mst[i] == M_RUN) begin
                    if (secs[i] == LIM_SECS) begin
                        if (i == 1) secs[i] = 0;
                        else        ns = M_DONE;
                    end else begin
                        secs[i]++;
                    end
                end
                if (st) begin
                    if (mst[i] == M_IDLE || mst[i] == M_PAUSE) ns = M_RUN;
                    else if (mst[i] == M_RUN && ns == M_RUN)   ns = M_PAUSE;
                end
                mst[i] = ns;
            end
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, "_dig0"},  dig0, to_bcd(secs[0]));
        chk({tag, "_dig1"},  dig1, to_bcd(secs[1]));
        chk({tag, "_run0"},  {15'b0, run0},  {15'b0, mst[0] == M_RUN});
        chk({tag, "_run1"},  {15'b0, run1},  {15'b0, mst[1] == M_RUN});
        chk({tag, "_done0"}, {15'b0, done0}, {15'b0, mst[0] == M_DONE});
        chk({tag, "_done1"}, {15'b0, done1}, 16'h0000);
    endtask

    task automatic scan_step();
        logic [15:0] e0, e1;
        @(negedge clk) ftsd_clk = 2'($urandom);
        @(posedge clk) #1;
        e0 = to_bcd(secs[0]);
        e1 = to_bcd(secs[1]);
        chk("scan_ctl0", {12'b0, ctl0}, {12'b0, ~(4'b0001 << ftsd_clk)});
        chk("scan_bcd0", {12'b0, bcd0}, {12'b0, 4'(e0 >> (4 * ftsd_clk))});
        chk("scan_bcd1", {12'b0, bcd1}, {12'b0, 4'(e1 >> (4 * ftsd_clk))});
    endtask

    task automatic pulse(bit st, bit cl);
        @(negedge clk) begin btn_start = st; btn_clear = cl; end
        @(negedge clk) begin btn_start = 1'b0; btn_clear = 1'b0; end
        model_step(1'b0, st, cl);
    endtask

    // Buttons land on the edge that consumes the tick (4th edge after rise).
    task automatic tick(bit st = 1'b0, bit cl = 1'b0);
        @(negedge clk) sec_clk = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) begin btn_start = st; btn_clear = cl; end
        @(negedge clk) begin btn_start = 1'b0; btn_clear = 1'b0; end
        model_step(1'b1, st, cl);
        check_all("tick");
        repeat ($urandom_range(0, 1)) @(negedge clk);
        sec_clk = 1'b0;
        scan_step();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [3:0] ctl_tab [4];
        logic [3:0] bcd_tab [4];
        ctl_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        bcd_tab = '{4'd4, 4'd3, 4'd2, 4'd1};

        rst = 1'b1; sec_clk = 1'b0; btn_start = 1'b0; btn_clear = 1'b0; ftsd_clk = 2'b00;
        secs = '{0, 0};
        mst  = '{M_IDLE, M_IDLE};

        repeat (3) @(negedge clk);
        chk("rst_ctl",  {12'b0, ctl0}, 16'h000F);
        chk("rst_bcd",  {12'b0, bcd0}, 16'h0000);
        chk("rst_dig",  dig0, 16'h0000);
        chk("rst_run",  {15'b0, run0}, 16'h0000);
        chk("rst_done", {15'b0, done0}, 16'h0000);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_all("idle");

        // Exact tick latency: count lands on the 4th edge after sec_clk rises.
        pulse(1'b1, 1'b0);
        check_all("start");
        @(negedge clk) sec_clk = 1'b1;
        @(posedge clk) #1 chk("lat_e1", dig0, 16'h0000);
        @(posedge clk) #1 chk("lat_e2", dig0, 16'h0000);
        @(posedge clk) #1 chk("lat_e3", dig0, 16'h0000);
        @(posedge clk) #1 chk("lat_e4", dig0, 16'h0001);
        model_step(1'b1, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("lat_hold", dig0, 16'h0001);
        sec_clk = 1'b0;
        repeat (4) @(negedge clk);

        repeat (4) tick();
        chk("at_0005", dig0, 16'h0005);
        tick(1'b1, 1'b0);
        chk("col_run_dig", dig0, 16'h0006);
        chk("col_run_st",  {15'b0, run0}, 16'h0000);
        tick(1'b1, 1'b0);
        chk("col_pause_dig", dig0, 16'h0006);
        chk("col_pause_st",  {15'b0, run0}, 16'h0001);

        while (secs[0] < LIM_SECS) begin
            tick();
            if (secs[0] == 60)  chk("carry_0100", dig0, 16'h0100);
            if (secs[0] == 600) chk("carry_1000", dig0, 16'h1000);
        end
        chk("at_limit", dig0, 16'h5959);

        tick();
        chk("lim_hold_dig", dig0, 16'h5959);
        chk("lim_done",     {15'b0, done0}, 16'h0001);
        chk("lim_run0",     {15'b0, run0}, 16'h0000);
        chk("wrap_dig",     dig1, 16'h0000);
        chk("wrap_run",     {15'b0, run1}, 16'h0001);

        pulse(1'b1, 1'b0);
        check_all("done_start");
        chk("done_ignore", {15'b0, done0}, 16'h0001);
        pulse(1'b0, 1'b1);
        check_all("done_clear");
        chk("clear_dig", dig0, 16'h0000);

        pulse(1'b1, 1'b0);
        tick();
        pulse(1'b1, 1'b1);
        check_all("start_clear");
        chk("sc_dig", dig0, 16'h0000);
        chk("sc_run", {15'b0, run0}, 16'h0000);

        pulse(1'b1, 1'b0);
        repeat (754) tick();
        pulse(1'b1, 1'b0);
        chk("at_1234", dig0, 16'h1234);
        for (int s = 0; s < 4; s++) begin
            @(negedge clk) ftsd_clk = 2'(s);
            @(posedge clk) #1;
            chk("sweep_ctl", {12'b0, ctl0}, {12'b0, ctl_tab[s]});
            chk("sweep_bcd", {12'b0, bcd0}, {12'b0, bcd_tab[s]});
        end

        pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b0);
        repeat (207) tick();
        chk("at_0327", dig0, 16'h0327);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_ctl", {12'b0, ctl0}, 16'h000F);
        chk("arst_dig", dig0, 16'h0000);
        chk("arst_run", {15'b0, run0}, 16'h0000);
        secs = '{0, 0};
        mst  = '{M_IDLE, M_IDLE};
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check_all("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
